ram_access_arbiter: RTL and testbench

- Shares the single data RAM port between the ALU's memory-capable instruction units: I-load, S-store, A-atomic, F-load/store, and the C-format CI, CSS, CL and CS units.
- Each unit raises a CE/RD/WR request. The arbiter grants one at a time (round-robin), sequences a fixed-latency RAM access, and returns an acknowledge plus read data to the winner.
- Sits between the ALU's RAM_* requester buses and the data RAM.

---
 rtl/ram_access_arbiter_if.sv | 52 +++++
 rtl/ram_access_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter_if
//
// Bundles the requester side (the ALU's RAM_* request buses) and the data
// RAM side of ram_access_arbiter into one interface.
//
// Signals:
//   iREQ_CE/RD/WR   per-requester request, read and write flags
//   iREQ_ADDR       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   iREQ_WDATA      packed write data, requester i at [i*DATA_W +: DATA_W]
//   oACK            one-hot completion pulse
//   oRDATA          read data, valid while oACK != 0
//   oBUSY           arbiter not idle
//   oRAM_CE/RD/WR   RAM chip enable and strobes
//   oRAM_ADDR       RAM address
//   oRAM_DATA       RAM write data
//   iRAM_DATA       RAM read data
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding logic (requesters plus the RAM)
// ---------------------------------------------------------------------------
interface ram_access_arbiter_if #(
  parameter int N_REQ  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        iREQ_CE;
  logic [N_REQ-1:0]        iREQ_RD;
  logic [N_REQ-1:0]        iREQ_WR;
  logic [N_REQ*ADDR_W-1:0] iREQ_ADDR;
  logic [N_REQ*DATA_W-1:0] iREQ_WDATA;
  logic [N_REQ-1:0]        oACK;
  logic [DATA_W-1:0]       oRDATA;
  logic                    oBUSY;
  logic                    oRAM_CE;
  logic                    oRAM_RD;
  logic                    oRAM_WR;
  logic [ADDR_W-1:0]       oRAM_ADDR;
  logic [DATA_W-1:0]       oRAM_DATA;
  logic [DATA_W-1:0]       iRAM_DATA;

  modport slave (
    input  iREQ_CE, iREQ_RD, iREQ_WR, iREQ_ADDR, iREQ_WDATA, iRAM_DATA,
    output oACK, oRDATA, oBUSY, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
  );

  modport master (
    output iREQ_CE, iREQ_RD, iREQ_WR, iREQ_ADDR, iREQ_WDATA, iRAM_DATA,
    input  oACK, oRDATA, oBUSY, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
//
// Shares the single data RAM port between the ALU's memory-capable units
// (0=I, 1=S, 2=A, 3=F, 4=CI, 5=CSS, 6=CL, 7=CS). One request is granted at a
// time; the winner's op is strobed to the RAM for one cycle, the arbiter then
// waits RAM_LAT cycles, and finally pulses oACK for the winner together with
// the read data (0 for writes and null ops).
//
// Sequence: IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> DONE -> IDLE
//   request sampled in IDLE at t, strobe at t+1, ACK at t+2+RAM_LAT.
//
// Ports:
//   iCLK  clock
//   iRST  synchronous active-high reset; drops any in-flight access, no ACK
//   bus   ram_access_arbiter_if.slave (requester buses and RAM port)
//
// Parameters:
//   N_REQ   number of requesters (>= 2)
//   ADDR_W  RAM address width
//   DATA_W  RAM data width
//   RAM_LAT RAM read latency, strobe to valid iRAM_DATA, legal range 1..7
//
// Build option:
//   RAM_ARB_FIXED_PRIO_EN  when defined, lowest index always wins and the
//                          round-robin pointer is removed (no starvation
//                          bound). Default is round-robin.
// ---------------------------------------------------------------------------
module ram_access_arbiter #(
  parameter int N_REQ   = 8,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input logic                iCLK,
  input logic                iRST,
  ram_access_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] grant_reg;
  logic             op_rd_reg;   // latched op is a pure read (write wins a RD+WR conflict)
  logic [CNT_W-1:0] cnt_reg;

  // -------------------------------------------------------------------------
  // Unpacked views of the packed requester address / data buses
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] req_addr  [N_REQ];
  logic [DATA_W-1:0] req_wdata [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_addr[gi]  = bus.iREQ_ADDR[gi*ADDR_W +: ADDR_W];
      assign req_wdata[gi] = bus.iREQ_WDATA[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0] search_vec;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign search_vec = bus.iREQ_CE;
`else
  logic [IDX_W-1:0] rr_reg;
  logic [N_REQ-1:0] hi_mask;

  // Requests at or above the pointer take precedence; if none exist the
  // search wraps to the lowest set request overall. This is the same as a
  // modulo-N scan starting at the pointer, without needing a modulo.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hi_mask
      assign hi_mask[gi] = bus.iREQ_CE[gi] & ({1'b0, rr_reg} <= (IDX_W+1)'(gi));
    end
  endgenerate

  assign search_vec = (|hi_mask) ? hi_mask : bus.iREQ_CE;
`endif

  assign win_found = |bus.iREQ_CE;

  // Lowest set bit of search_vec.
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (search_vec[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

  logic win_rd;
  logic win_wr;
  assign win_rd = bus.iREQ_RD[win_idx];
  assign win_wr = bus.iREQ_WR[win_idx];

  // -------------------------------------------------------------------------
  // Sequencer. All outputs are registered and updated on the transition
  // into the state they belong to.
  // -------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      op_rd_reg     <= 1'b0;
      cnt_reg       <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_reg        <= '0;
`endif
      bus.oACK      <= '0;
      bus.oRDATA    <= '0;
      bus.oBUSY     <= 1'b0;
      bus.oRAM_CE   <= 1'b0;
      bus.oRAM_RD   <= 1'b0;
      bus.oRAM_WR   <= 1'b0;
      bus.oRAM_ADDR <= '0;
      bus.oRAM_DATA <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          bus.oACK   <= '0;
          bus.oRDATA <= '0;
          if (win_found) begin
            // Everything the access needs is captured here; later changes
            // on the requester side have no effect on this transaction.
            state_reg     <= ISSUE;
            grant_reg     <= win_idx;
            op_rd_reg     <= win_rd & ~win_wr;
            bus.oBUSY     <= 1'b1;
            // A null op (neither RD nor WR) runs the full sequence with the
            // chip enable kept low.
            bus.oRAM_CE   <= win_rd | win_wr;
            bus.oRAM_RD   <= win_rd & ~win_wr;
            bus.oRAM_WR   <= win_wr;
            bus.oRAM_ADDR <= req_addr[win_idx];
            bus.oRAM_DATA <= req_wdata[win_idx];
          end else begin
            bus.oBUSY     <= 1'b0;
            bus.oRAM_CE   <= 1'b0;
            bus.oRAM_RD   <= 1'b0;
            bus.oRAM_WR   <= 1'b0;
            bus.oRAM_ADDR <= '0;
            bus.oRAM_DATA <= '0;
          end
        end

        ISSUE: begin
          // Strobes last exactly one cycle; address and data stay put.
          state_reg   <= WAIT;
          cnt_reg     <= CNT_W'(RAM_LAT);
          bus.oRAM_CE <= 1'b0;
          bus.oRAM_RD <= 1'b0;
          bus.oRAM_WR <= 1'b0;
        end

        WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            // Last wait cycle: iRAM_DATA is valid now, RAM_LAT cycles after
            // the strobe cycle.
            state_reg  <= DONE;
            bus.oACK   <= N_REQ'(1) << grant_reg;
            bus.oRDATA <= op_rd_reg ? bus.iRAM_DATA : '0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        DONE: begin
          state_reg     <= IDLE;
          bus.oACK      <= '0;
          bus.oRDATA    <= '0;
          bus.oBUSY     <= 1'b0;
          bus.oRAM_ADDR <= '0;
          bus.oRAM_DATA <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          rr_reg <= (grant_reg == IDX_W'(N_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
`endif
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_access_arbiter
//
// Two arbiters: bus1/dut1 with RAM_LAT=1 behind a small RAM model, and
// bus3/dut3 with RAM_LAT=3 whose read data is driven directly by the
// stimulus in exactly one cycle. The stimulus pushes expected ACKs and
// expected output snapshots (with the cycle they are due) into queues; one
// monitor process compares them against the DUT outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;
  localparam int N  = 8;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst3;
  int   cyc = 0;
  logic tb_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  ram_access_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  ram_access_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  ram_access_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut1 (
    .iCLK(clk), .iRST(rst1), .bus(bus1)
  );
  ram_access_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) dut3 (
    .iCLK(clk), .iRST(rst3), .bus(bus3)
  );

  // ---------------- RAM model for bus1 (latency 1) ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
  endfunction

  logic [31:0] mem [256];
  logic        rd_vld;
  logic [31:0] rd_word;

  always @(posedge clk) begin
    if (rst1) begin
      rd_vld <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      rd_vld  <= bus1.oRAM_CE && bus1.oRAM_RD;
      rd_word <= mem[bus1.oRAM_ADDR];
      if (bus1.oRAM_CE && bus1.oRAM_WR) mem[bus1.oRAM_ADDR] <= bus1.oRAM_DATA;
    end
  end
  // Outside the valid cycle the RAM shows a junk pattern.
  assign bus1.iRAM_DATA = rd_vld ? rd_word : JUNK;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          at;
    int          b;
    logic [7:0]  ack;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct {
    string       name;
    int          at;
    int          b;
    logic [3:0]  ctl;     // {ce, rd, wr, busy}
    logic [7:0]  addr;
    logic [31:0] data;
    logic        data_chk;
    logic [7:0]  ack;
    logic [31:0] rdata;
  } snap_t;

  ack_exp_t ack_q[$];
  snap_t    snap_q[$];

  task automatic exp_ack(input string nm, input int at, input int b,
                         input logic [7:0] ack, input logic [31:0] rdata);
    ack_exp_t e;
    e.name = nm; e.at = at; e.b = b; e.ack = ack; e.rdata = rdata;
    ack_q.push_back(e);
  endtask

  task automatic exp_snap(input string nm, input int at, input int b, input logic [3:0] ctl,
                          input logic [7:0] addr, input logic [31:0] data, input logic dchk);
    snap_t e;
    e.name = nm; e.at = at; e.b = b; e.ctl = ctl; e.addr = addr;
    e.data = data; e.data_chk = dchk; e.ack = 8'h00; e.rdata = 32'h0;
    snap_q.push_back(e);
  endtask

  task automatic check_ack(input int b, input logic [7:0] ack, input logic [31:0] rdata);
    ack_exp_t e;
    if (ack != 8'h00) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack bus%0d cyc %0d: got ack=%h rdata=%h, required no ack",
                 b, cyc, ack, rdata);
      end else begin
        e = ack_q.pop_front();
        if (e.b != b || e.ack !== ack || e.rdata !== rdata || e.at != cyc) begin
          errors++;
          $display("FAIL %s: got bus%0d cyc %0d ack=%h rdata=%h, required bus%0d cyc %0d ack=%h rdata=%h",
                   e.name, b, cyc, ack, rdata, e.b, e.at, e.ack, e.rdata);
        end else begin
          $display("ack %s bus%0d cyc %0d ack=%h rdata=%h ok", e.name, b, cyc, ack, rdata);
        end
      end
    end
  endtask

  task automatic check_snap(input snap_t e);
    logic [3:0]  a_ctl;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    logic [7:0]  a_ack;
    logic [31:0] a_rdata;
    if (e.b == 0) begin
      a_ctl = {bus1.oRAM_CE, bus1.oRAM_RD, bus1.oRAM_WR, bus1.oBUSY};
      a_addr = bus1.oRAM_ADDR; a_data = bus1.oRAM_DATA; a_ack = bus1.oACK; a_rdata = bus1.oRDATA;
    end else begin
      a_ctl = {bus3.oRAM_CE, bus3.oRAM_RD, bus3.oRAM_WR, bus3.oBUSY};
      a_addr = bus3.oRAM_ADDR; a_data = bus3.oRAM_DATA; a_ack = bus3.oACK; a_rdata = bus3.oRDATA;
    end
    checks++;
    if (a_ctl !== e.ctl || a_addr !== e.addr || (e.data_chk && a_data !== e.data) ||
        a_ack !== e.ack || a_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s bus%0d cyc %0d: got ce/rd/wr/busy=%b addr=%h data=%h ack=%h rdata=%h, required ce/rd/wr/busy=%b addr=%h data=%h(chk=%b) ack=%h rdata=%h",
               e.name, e.b, cyc, a_ctl, a_addr, a_data, a_ack, a_rdata,
               e.ctl, e.addr, e.data, e.data_chk, e.ack, e.rdata);
    end else begin
      $display("snap %s bus%0d cyc %0d ok", e.name, e.b, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ack_exp_t ea;
    snap_t    es;
    check_ack(0, bus1.oACK, bus1.oRDATA);
    check_ack(1, bus3.oACK, bus3.oRDATA);
    while (ack_q.size() > 0 && ack_q[0].at < cyc) begin
      ea = ack_q.pop_front();
      checks++; errors++;
      $display("FAIL %s: got no ack by cyc %0d, required bus%0d ack=%h rdata=%h at cyc %0d",
               ea.name, cyc, ea.b, ea.ack, ea.rdata, ea.at);
    end
    while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
      es = snap_q.pop_front();
      if (es.at < cyc) begin
        checks++; errors++;
        $display("FAIL %s: got snapshot missed at cyc %0d, required cyc %0d", es.name, cyc, es.at);
      end else begin
        check_snap(es);
      end
    end
    if (tb_done || cyc > 2000) begin
      if (!tb_done) begin
        checks++; errors++;
        $display("FAIL timeout: got cyc %0d, required stimulus done by cyc 2000", cyc);
      end
      foreach (ack_q[i]) begin
        checks++; errors++;
        $display("FAIL %s: got no ack, required ack=%h", ack_q[i].name, ack_q[i].ack);
      end
      foreach (snap_q[i]) begin
        checks++; errors++;
        $display("FAIL %s: got no snapshot, required cyc %0d", snap_q[i].name, snap_q[i].at);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int b, input int i, input logic ce, input logic rd, input logic wr,
                         input logic [7:0] addr, input logic [31:0] wd);
    if (b == 0) begin
      bus1.iREQ_CE[i] = ce; bus1.iREQ_RD[i] = rd; bus1.iREQ_WR[i] = wr;
      bus1.iREQ_ADDR[i*AW +: AW] = addr; bus1.iREQ_WDATA[i*DW +: DW] = wd;
    end else begin
      bus3.iREQ_CE[i] = ce; bus3.iREQ_RD[i] = rd; bus3.iREQ_WR[i] = wr;
      bus3.iREQ_ADDR[i*AW +: AW] = addr; bus3.iREQ_WDATA[i*DW +: DW] = wd;
    end
  endtask

  initial begin
    int c;
    logic [7:0] pending;
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.iREQ_CE = '0; bus1.iREQ_RD = '0; bus1.iREQ_WR = '0;
    bus1.iREQ_ADDR = '0; bus1.iREQ_WDATA = '0;
    bus3.iREQ_CE = '0; bus3.iREQ_RD = '0; bus3.iREQ_WR = '0;
    bus3.iREQ_ADDR = '0; bus3.iREQ_WDATA = '0;
    bus3.iRAM_DATA = JUNK;

    // Reset state
    tick(2);
    exp_snap("reset_state", cyc + 1, 0, 4'b0000, 8'h00, 32'h0, 1'b1);
    exp_snap("reset_state", cyc + 1, 1, 4'b0000, 8'h00, 32'h0, 1'b1);
    tick(1);
    rst1 = 1'b0; rst3 = 1'b0;
    tick(2);

    // Single read, req 0
    c = cyc;
    set_req(0, 0, 1'b1, 1'b1, 1'b0, 8'h10, 32'h0);
    exp_snap("read_strobe", c + 1, 0, 4'b1101, 8'h10, 32'h0, 1'b1);
    exp_ack("read_ack", c + 3, 0, 8'h01, 32'hDEAD_BEEF);
    tick(1); set_req(0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0); tick(4);

    // Single write, req 5
    c = cyc;
    set_req(0, 5, 1'b1, 1'b0, 1'b1, 8'h20, 32'h1234_5678);
    exp_snap("write_strobe", c + 1, 0, 4'b1011, 8'h20, 32'h1234_5678, 1'b1);
    exp_snap("write_one_cycle", c + 2, 0, 4'b0001, 8'h20, 32'h0, 1'b0);
    exp_ack("write_ack", c + 3, 0, 8'h20, 32'h0);
    tick(1); set_req(0, 5, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0); tick(4);

    // Read back 0x20 through req 1
    c = cyc;
    set_req(0, 1, 1'b1, 1'b1, 1'b0, 8'h20, 32'h0);
    exp_ack("readback_ack", c + 3, 0, 8'h02, 32'h1234_5678);
    tick(1); set_req(0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0); tick(4);

    // RD+WR conflict, req 2: write wins
    c = cyc;
    set_req(0, 2, 1'b1, 1'b1, 1'b1, 8'h30, 32'hCAFE_F00D);
    exp_snap("conflict_strobe", c + 1, 0, 4'b1011, 8'h30, 32'hCAFE_F00D, 1'b1);
    exp_ack("conflict_ack", c + 3, 0, 8'h04, 32'h0);
    tick(1); set_req(0, 2, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0); tick(4);

    // Null op, req 3
    c = cyc;
    set_req(0, 3, 1'b1, 1'b0, 1'b0, 8'h33, 32'h0);
    exp_snap("null_no_ce", c + 1, 0, 4'b0001, 8'h33, 32'h0, 1'b1);
    exp_ack("null_ack", c + 3, 0, 8'h08, 32'h0);
    tick(1); set_req(0, 3, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0); tick(4);

    // Reset during WAIT: no ACK, everything cleared
    c = cyc;
    set_req(0, 6, 1'b1, 1'b1, 1'b0, 8'h44, 32'h0);
    tick(1); set_req(0, 6, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(1); rst1 = 1'b1;
    exp_snap("reset_mid_op", c + 3, 0, 4'b0000, 8'h00, 32'h0, 1'b1);
    tick(1); rst1 = 1'b0;

    // Round-robin after reset: everyone requests, each drops CE after its ACK
    c = cyc;
    for (int i = 0; i < N; i++) begin
      set_req(0, i, 1'b1, 1'b1, 1'b0, 8'(8'h40 + i), 32'h0);
      exp_ack($sformatf("rr_ack%0d", i), c + 3 + 4 * i, 0, 8'(1 << i), 32'h1000_0040 + i);
    end
    pending = 8'hFF;
    for (int k = 0; k < 80 && pending != 8'h00; k++) begin
      tick(1);
      if (bus1.oACK != 8'h00) begin
        bus1.iREQ_CE = bus1.iREQ_CE & ~bus1.oACK;
        pending = pending & ~bus1.oACK;
      end
    end
    tick(2);

    // RAM_LAT=3: two pending reads on bus3
    c = cyc;
    set_req(1, 0, 1'b1, 1'b1, 1'b0, 8'h11, 32'h0);
    set_req(1, 4, 1'b1, 1'b1, 1'b0, 8'h22, 32'h0);
    exp_snap("lat3_strobe0", c + 1, 1, 4'b1101, 8'h11, 32'h0, 1'b1);
    exp_ack("lat3_ack0", c + 5, 1, 8'h01, 32'h55AA_1234);
    exp_snap("lat3_idle_gap", c + 6, 1, 4'b0000, 8'h00, 32'h0, 1'b1);
    exp_snap("lat3_strobe4", c + 7, 1, 4'b1101, 8'h22, 32'h0, 1'b1);
    exp_ack("lat3_ack4", c + 11, 1, 8'h10, 32'h0BAD_CAFE);
    tick(1); set_req(1, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(3); bus3.iRAM_DATA = 32'h55AA_1234;
    tick(1); bus3.iRAM_DATA = JUNK;
    tick(2); set_req(1, 4, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(3); bus3.iRAM_DATA = 32'h0BAD_CAFE;
    tick(1); bus3.iRAM_DATA = JUNK;
    tick(3);
    tb_done = 1'b1;
  end

endmodule
